// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register slave.
// Contents: FSM state encoding, rw bit meaning, default byte size and
// synchroniser depth.
package spi_pkg;

  localparam int unsigned PACKAGE_SIZE_DEF = 8;
  localparam int unsigned SYNC_DEPTH       = 2;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall detection
// on the synchronised level.
// Ports:
//   clk, rstb : system clock, async active-low reset
//   din       : asynchronous input pin
//   rise_c    : one-clk pulse after a synchronised 0->1 transition
//   fall_c    : one-clk pulse after a synchronised 1->0 transition
// RST_LEVEL sets the idle level the chain resets to, so that leaving reset
// does not look like an edge.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= {SYNC_DEPTH{RST_LEVEL}};
      prev_q <= RST_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign rise_c = sync_q[SYNC_DEPTH-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_DEPTH-1] & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder with a local register file.
// Frame: {rw, addr[PACKAGE_SIZE-2:0]} command byte then one data byte,
// MSB first. rw=1 reads, rw=0 writes. SPI pins are oversampled on clk.
// Ports:
//   clk, rstb          : system clock (>= 8x SCLK), async active-low reset
//   sclk, csb, mosi    : asynchronous SPI pins from the master
//   miso, miso_oe      : slave data out and its tristate enable
//   ld_en/addr/data    : local register preload
//   wr_strb/addr/data  : one-clk notification of a master write
//   frame_err          : one-clk pulse on an aborted frame
//   addr_err           : one-clk pulse on access to an unmapped address
// Optional build macro SPI_SLAVE_BURST_EN: while csb stays low, data bytes
// continue at auto-incremented addresses instead of stopping after one byte.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int unsigned              PACKAGE_SIZE = PACKAGE_SIZE_DEF,
  parameter int unsigned              REG_DEPTH    = 32,
  parameter logic [PACKAGE_SIZE-1:0]  RST_VAL      = '0
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    sclk,
  input  logic                    csb,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic                    ld_en,
  input  logic [PACKAGE_SIZE-2:0] ld_addr,
  input  logic [PACKAGE_SIZE-1:0] ld_data,
  output logic                    wr_strb,
  output logic [PACKAGE_SIZE-2:0] wr_addr,
  output logic [PACKAGE_SIZE-1:0] wr_data,
  output logic                    frame_err,
  output logic                    addr_err
);

  localparam int unsigned PS = PACKAGE_SIZE;
  localparam int unsigned AW = PACKAGE_SIZE - 1;
  localparam int unsigned CW = $clog2(PACKAGE_SIZE + 1);
  localparam int unsigned IW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  // Synchronised pin events
  logic sclk_rise_c, sclk_fall_c, csb_rise_c, csb_fall_c;
  logic [SYNC_DEPTH-1:0] mosi_sync_q;
  logic                  mosi_s;

  spi_sync_edge #(.RST_LEVEL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rstb   (rstb),
    .din    (sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.RST_LEVEL(1'b1)) u_csb_sync (
    .clk    (clk),
    .rstb   (rstb),
    .din    (csb),
    .rise_c (csb_rise_c),
    .fall_c (csb_fall_c)
  );

  // mosi needs only the level, aligned with the sclk chain
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_DEPTH-1];

  // State and datapath registers
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PS-2:0]   ishift_q, ishift_d;
  logic [PS-1:0]   oshift_q, oshift_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            miso_q, miso_d;
  logic            oe_q, oe_d;
  logic            wr_strb_q, wr_strb_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [PS-1:0]   wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;
  logic            addr_err_q, addr_err_d;
`ifdef SPI_SLAVE_BURST_EN
  // Unmapped prefetch: error is reported when that byte starts shifting out
  logic            pend_q, pend_d;
`endif

  logic [PS-1:0]   regs [REG_DEPTH];

  // Helper decodes
  logic [PS-1:0]   byte_c;
  logic            last_rise_c;
  logic [AW-1:0]   next_addr_c;
  logic [AW-1:0]   rd_addr_c;
  logic            rd_mapped_c;
  logic [PS-1:0]   rd_data_c;
  logic            wr_mapped_c;
  logic            reg_we_c;

  assign byte_c      = {ishift_q, mosi_s};
  assign last_rise_c = (cnt_q == CW'(PS - 1));
  assign next_addr_c = addr_q + AW'(1);
  // Command latch reads the address just received; burst reloads the next one
  assign rd_addr_c   = (state_q == ST_CMD) ? byte_c[AW-1:0] : next_addr_c;
  assign rd_mapped_c = (32'(rd_addr_c) < REG_DEPTH);
  assign rd_data_c   = rd_mapped_c ? regs[IW'(rd_addr_c)] : '0;
  assign wr_mapped_c = (32'(addr_q) < REG_DEPTH);

  // Register file: an SPI write beats a local load to the same address
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs[IW'(i)] <= RST_VAL;
    end else begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) begin
        if (reg_we_c && (addr_q == AW'(i)))      regs[IW'(i)] <= byte_c;
        else if (ld_en && (ld_addr == AW'(i)))   regs[IW'(i)] <= ld_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ishift_q    <= '0;
      oshift_q    <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strb_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ishift_q    <= ishift_d;
      oshift_q    <= oshift_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strb_q   <= wr_strb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
`ifdef SPI_SLAVE_BURST_EN
      pend_q      <= pend_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ishift_d    = ishift_q;
    oshift_d    = oshift_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strb_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    reg_we_c    = 1'b0;
`ifdef SPI_SLAVE_BURST_EN
    pend_d      = pend_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        oe_d   = 1'b0;
        miso_d = 1'b0;
`ifdef SPI_SLAVE_BURST_EN
        pend_d = 1'b0;
`endif
        if (csb_fall_c) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          oe_d    = 1'b1;
        end
      end

      ST_CMD: begin
        if (csb_rise_c) begin
          // Deselect before any clock is harmless; mid-byte is an abort
          state_d     = ST_IDLE;
          oe_d        = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
        end else if (sclk_rise_c) begin
          ishift_d = byte_c[PS-2:0];
          if (last_rise_c) begin
            cnt_d  = '0;
            addr_d = byte_c[AW-1:0];
            if (byte_c[PS-1] == RW_WRITE) begin
              state_d = ST_WDATA;
            end else begin
              state_d    = ST_RDATA;
              oshift_d   = rd_data_c;
              addr_err_d = ~rd_mapped_c;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_WDATA: begin
        if (csb_rise_c) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          cnt_d   = '0;
`ifdef SPI_SLAVE_BURST_EN
          // Between bytes of a burst, deselect is the normal end of frame
          frame_err_d = (cnt_q != '0);
`else
          frame_err_d = 1'b1;
`endif
        end else if (sclk_rise_c) begin
          ishift_d = byte_c[PS-2:0];
          if (last_rise_c) begin
            cnt_d = '0;
            if (wr_mapped_c) begin
              reg_we_c  = 1'b1;
              wr_strb_d = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_c;
            end else begin
              addr_err_d = 1'b1;
            end
`ifdef SPI_SLAVE_BURST_EN
            addr_d = next_addr_c;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_RDATA: begin
        if (csb_rise_c) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          cnt_d   = '0;
`ifdef SPI_SLAVE_BURST_EN
          frame_err_d = (cnt_q != '0);
          pend_d      = 1'b0;
`else
          frame_err_d = 1'b1;
`endif
        end else if (sclk_fall_c) begin
          miso_d   = oshift_q[PS-1];
          oshift_d = {oshift_q[PS-2:0], 1'b0};
`ifdef SPI_SLAVE_BURST_EN
          if ((cnt_q == '0) && pend_q) begin
            addr_err_d = 1'b1;
            pend_d     = 1'b0;
          end
`endif
        end else if (sclk_rise_c) begin
          if (last_rise_c) begin
            cnt_d = '0;
`ifdef SPI_SLAVE_BURST_EN
            addr_d   = next_addr_c;
            oshift_d = rd_data_c;
            pend_d   = ~rd_mapped_c;
`else
            state_d = ST_DONE;
            miso_d  = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_DONE: begin
        miso_d = 1'b0;
        if (csb_rise_c) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign wr_strb   = wr_strb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign addr_err  = addr_err_q;

endmodule
